// File: rtl/keccak_pkg.sv
// Shared constants, FSM state encoding and width helpers for the Keccak
// load/unload sequencer.
package keccak_pkg;

  localparam int LANES  = 32'sd25;
  localparam int ROUNDS = 32'sd12;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_RUN    = 4'b0100,
    ST_UNLOAD = 4'b1000
  } io_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // Index fields never collapse to zero width, even with a single share.
  function automatic int idx_w(input int n);
    int r;
    r = clog2(n);
    if (r < 32'sd1) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_lane_counter.sv
// Lane-major (lane, share) index counter shared by the load and unload phases;
// wraps from (LANES-1, SHARES-1) back to (0, 0).
module keccak_lane_counter
  import keccak_pkg::*;
#(
  parameter int SHARES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [4:0]                lane_o,
  output logic [idx_w(SHARES)-1:0]  share_o,
  output logic                      last_o
);

  localparam int SW = idx_w(SHARES);

  logic [4:0]    lane_d,  lane_q;
  logic [SW-1:0] share_d, share_q;
  logic          lane_end, share_end;

  assign lane_end  = (lane_q == 5'(LANES - 1));
  assign share_end = (share_q == SW'(SHARES - 1));

  // Next index: clear wins over advance; shares step fastest within a lane.
  always_comb begin
    lane_d  = lane_q;
    share_d = share_q;
    if (clr_i) begin
      lane_d  = 5'd0;
      share_d = SW'(0);
    end else if (en_i) begin
      if (share_end) begin
        share_d = SW'(0);
        if (lane_end) begin
          lane_d = 5'd0;
        end else begin
          lane_d = lane_q + 5'd1;
        end
      end else begin
        share_d = share_q + SW'(1);
      end
    end else begin
      lane_d  = lane_q;
      share_d = share_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= 5'd0;
      share_q <= SW'(0);
    end else begin
      lane_q  <= lane_d;
      share_q <= share_d;
    end
  end

  assign lane_o  = lane_q;
  assign share_o = share_q;
  assign last_o  = lane_end & share_end;

endmodule

// File: rtl/keccak_io_ctrl.sv
// Load/unload sequencer in front of keccak_control: streams masked lane shares
// into the datapath, runs the core, then streams the masked result out.
module keccak_io_ctrl
  import keccak_pkg::*;
#(
  parameter int W       = 8,
  parameter int SHARES  = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [W-1:0]              InData,
  output logic                      LoadEn,
  output logic [W-1:0]              LoadData,
  output logic [4:0]                LaneIdx,
  output logic [idx_w(SHARES)-1:0]  ShareIdx,
  output logic                      CoreReset,
  input  logic                      CoreReady,
  input  logic [W-1:0]              StateLane,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [W-1:0]              OutData,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Error
);

  localparam int RCW = clog2(TIMEOUT + 1);

  io_state_e      state_d, state_q;
  logic [RCW-1:0] run_cnt_d, run_cnt_q;
  logic           core_reset_d, core_reset_q;
  logic           error_d, error_q;
  logic           done_d, done_q;
  logic           cnt_clr, cnt_en, last;

  keccak_lane_counter #(
    .SHARES (SHARES)
  ) u_lane_counter (
    .clk     (Clock),
    .rst     (Reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .lane_o  (LaneIdx),
    .share_o (ShareIdx),
    .last_o  (last)
  );

  // Handshake strobes decode straight from the state register.
  assign InReady  = (state_q == ST_LOAD);
  assign OutValid = (state_q == ST_UNLOAD);
  assign LoadEn   = InValid & InReady;
  assign LoadData = InData;
  assign OutData  = StateLane;
  assign Busy     = (state_q != ST_IDLE);

  // Next-state, counter control and flag updates.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    core_reset_d = core_reset_q;
    error_d      = error_q;
    done_d       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        core_reset_d = 1'b1;
        if (Start) begin
          state_d = ST_LOAD;
          error_d = 1'b0;
          cnt_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        core_reset_d = 1'b1;
        if (InValid) begin
          cnt_en = 1'b1;
          if (last) begin
            state_d      = ST_RUN;
            core_reset_d = 1'b0;
            run_cnt_d    = RCW'(0);
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        core_reset_d = 1'b0;
        if (CoreReady) begin
          state_d   = ST_UNLOAD;
          cnt_clr   = 1'b1;
          run_cnt_d = RCW'(0);
        end else if (run_cnt_q == RCW'(TIMEOUT)) begin
          state_d      = ST_IDLE;
          error_d      = 1'b1;
          core_reset_d = 1'b1;
          run_cnt_d    = RCW'(0);
        end else begin
          run_cnt_d = run_cnt_q + RCW'(1);
        end
      end
      ST_UNLOAD: begin
        // Core stays out of reset so the datapath holds its result.
        core_reset_d = 1'b0;
        if (OutReady) begin
          cnt_en = 1'b1;
          if (last) begin
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            core_reset_d = 1'b1;
          end else begin
            state_d = ST_UNLOAD;
          end
        end else begin
          state_d = ST_UNLOAD;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        run_cnt_d    = RCW'(0);
        core_reset_d = 1'b1;
        cnt_clr      = 1'b1;
      end
    endcase
  end

  // State, run counter and registered control outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      run_cnt_q    <= RCW'(0);
      core_reset_q <= 1'b1;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      core_reset_q <= core_reset_d;
      error_q      <= error_d;
      done_q       <= done_d;
    end
  end

  assign CoreReset = core_reset_q;
  assign Error     = error_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_keccak_io_ctrl.sv
// Randomised self-checking bench for keccak_io_ctrl with a behavioural core and
// datapath model; expected indices and data come from word order arithmetic.
module tb_keccak_io_ctrl;

  localparam int W       = 8;
  localparam int SHARES  = 2;
  localparam int TIMEOUT = 31;
  localparam int SW      = 1;
  localparam int NW      = 25 * SHARES;
  localparam int NOMINAL_RUN = 13;

  logic          Clock = 1'b0;
  logic          Reset, Start, InValid, OutReady;
  logic [W-1:0]  InData, LoadData, OutData, StateLane;
  logic          InReady, LoadEn, CoreReset, CoreReady, OutValid, Busy, Done, Error;
  logic [4:0]    LaneIdx;
  logic [SW-1:0] ShareIdx;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int core_cnt = 0;
  logic core_en;
  logic [W-1:0] mem [0:63];
  logic [W-1:0] exp_words [0:NW-1];

  always #5 Clock = ~Clock;

  keccak_io_ctrl #(.W(W), .SHARES(SHARES), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady),
    .InData(InData), .LoadEn(LoadEn), .LoadData(LoadData), .LaneIdx(LaneIdx),
    .ShareIdx(ShareIdx), .CoreReset(CoreReset), .CoreReady(CoreReady),
    .StateLane(StateLane), .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  // Environment: datapath stores loaded shares; the "permutation" result is share ^ 8'h5A.
  always @(posedge Clock) if (LoadEn === 1'b1) mem[{LaneIdx, ShareIdx}] <= LoadData;
  assign StateLane = mem[{LaneIdx, ShareIdx}] ^ 8'h5A;

  // Core model: Ready after 13 cycles out of reset, held while out of reset.
  always @(posedge Clock) begin
    if (CoreReset !== 1'b0) core_cnt <= 0;
    else if (core_cnt < 1000) core_cnt <= core_cnt + 1;
  end
  assign CoreReady = core_en && (CoreReset === 1'b0) && (core_cnt >= NOMINAL_RUN - 1);

  always @(posedge Clock) if (Done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic fill_words(input bit ramp);
    for (int i = 0; i < NW; i++) exp_words[i] = ramp ? W'(i) : W'($urandom);
  endtask

  task automatic start_seq();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    vectors++;
    if (InReady !== 1'b1 || Error !== 1'b0 || LaneIdx !== 5'd0 || ShareIdx !== 1'b0 || Busy !== 1'b1)
      begin miscompares++; $display("FAIL start: got InReady=%b Error=%b lane=%0d share=%0d Busy=%b, expected 1 0 0 0 1", InReady, Error, LaneIdx, ShareIdx, Busy); end
  endtask

  task automatic do_load(input bit toggle, input int abort_at);
    int k, guard;
    k = 0; guard = 0;
    while (k < NW && guard < 400) begin
      InValid = toggle ? ((guard % 2) == 0) : 1'b1;
      InData  = exp_words[k];
      @(negedge Clock);
      vectors++;
      if (InReady !== 1'b1 || OutValid !== 1'b0 || CoreReset !== 1'b1 || LoadEn !== InValid)
        begin miscompares++; $display("FAIL load_status k=%0d: got InReady=%b OutValid=%b CoreReset=%b LoadEn=%b, expected 1 0 1 %b", k, InReady, OutValid, CoreReset, LoadEn, InValid); end
      if (InValid) begin
        vectors++;
        if (LaneIdx !== 5'(k / SHARES) || ShareIdx !== SW'(k % SHARES) || LoadData !== exp_words[k])
          begin miscompares++; $display("FAIL load_index k=%0d: got lane=%0d share=%0d data=%h, expected lane=%0d share=%0d data=%h", k, LaneIdx, ShareIdx, LoadData, k / SHARES, k % SHARES, exp_words[k]); end
        k++;
      end
      guard++;
      @(posedge Clock); #1;
      if (k == abort_at) begin InValid = 1'b0; return; end
    end
    InValid = 1'b0;
    vectors++;
    if (k !== NW) begin miscompares++; $display("FAIL load_count: got %0d handshakes, expected %0d", k, NW); end
    vectors++;
    if (CoreReset !== 1'b0 || InReady !== 1'b0 || Busy !== 1'b1)
      begin miscompares++; $display("FAIL core_release: got CoreReset=%b InReady=%b Busy=%b, expected 0 0 1", CoreReset, InReady, Busy); end
  endtask

  task automatic do_run(input int exp_cycles, input bit noise);
    int cyc;
    cyc = 0;
    while (OutValid !== 1'b1 && Busy === 1'b1 && cyc < 64) begin
      Start = noise;
      vectors++;
      if (CoreReset !== 1'b0 || InReady !== 1'b0)
        begin miscompares++; $display("FAIL run_status cyc=%0d: got CoreReset=%b InReady=%b, expected 0 0", cyc, CoreReset, InReady); end
      @(posedge Clock); #1;
      cyc++;
    end
    vectors++;
    if (cyc !== exp_cycles) begin miscompares++; $display("FAIL run_length: got %0d cycles, expected %0d", cyc, exp_cycles); end
  endtask

  task automatic do_unload(input int stall_k, input int stall_n, input bit noise);
    int k, stalled, guard, d0;
    logic [W-1:0] held, expd;
    k = 0; stalled = 0; guard = 0; d0 = done_cnt; held = '0;
    while (k < NW && guard < 200) begin
      Start    = noise;
      OutReady = !(k == stall_k && stalled < stall_n);
      expd     = exp_words[k] ^ 8'h5A;
      @(negedge Clock);
      vectors++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || CoreReset !== 1'b0 || LaneIdx !== 5'(k / SHARES) || ShareIdx !== SW'(k % SHARES) || OutData !== expd)
        begin miscompares++; $display("FAIL unload_word k=%0d: got valid=%b rdy=%b crst=%b lane=%0d share=%0d data=%h, expected 1 0 0 lane=%0d share=%0d data=%h", k, OutValid, InReady, CoreReset, LaneIdx, ShareIdx, OutData, k / SHARES, k % SHARES, expd); end
      if (!OutReady) begin
        if (stalled > 0) begin
          vectors++;
          if (OutData !== held) begin miscompares++; $display("FAIL stall_hold: got %h, expected %h", OutData, held); end
        end
        held = OutData;
        stalled++;
      end
      @(posedge Clock); #1;
      if (OutReady) k++;
      guard++;
    end
    Start = 1'b0; OutReady = 1'b0;
    vectors++;
    if (k !== NW) begin miscompares++; $display("FAIL unload_count: got %0d handshakes, expected %0d", k, NW); end
    vectors++;
    if (Done !== 1'b1 || CoreReset !== 1'b1 || Busy !== 1'b0)
      begin miscompares++; $display("FAIL finish: got Done=%b CoreReset=%b Busy=%b, expected 1 1 0", Done, CoreReset, Busy); end
    @(posedge Clock); #1;
    vectors++;
    if (Done !== 1'b0 || (done_cnt - d0) !== 1)
      begin miscompares++; $display("FAIL done_pulse: got Done=%b pulses=%0d, expected 0 and 1 pulse", Done, done_cnt - d0); end
  endtask

  task automatic full_run(input bit ramp, input bit toggle, input int stall_k, input bit noise);
    fill_words(ramp);
    start_seq();
    do_load(toggle, -1);
    do_run(NOMINAL_RUN, noise);
    do_unload(stall_k, 3, noise);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    vectors++;
    if (CoreReset !== 1'b1 || Busy !== 1'b0 || InReady !== 1'b0 || OutValid !== 1'b0 || LaneIdx !== 5'd0 || ShareIdx !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || LoadEn !== 1'b0)
      begin miscompares++; $display("FAIL reset: got crst=%b busy=%b inrdy=%b outv=%b lane=%0d share=%0d done=%b err=%b, expected 1 0 0 0 0 0 0 0", CoreReset, Busy, InReady, OutValid, LaneIdx, ShareIdx, Done, Error); end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_nominal();
    full_run(1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    full_run(1'b0, 1'b1, 15, 1'b0);
  endtask

  task automatic test_timeout();
    core_en = 1'b0;
    fill_words(1'b0);
    start_seq();
    do_load(1'b0, -1);
    do_run(TIMEOUT + 1, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    vectors++;
    if (Busy !== 1'b0 || Error !== 1'b1 || CoreReset !== 1'b1 || OutValid !== 1'b0 || Done !== 1'b0)
      begin miscompares++; $display("FAIL timeout: got Busy=%b Error=%b CoreReset=%b OutValid=%b Done=%b, expected 0 1 1 0 0", Busy, Error, CoreReset, OutValid, Done); end
    core_en = 1'b1;
    full_run(1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    fill_words(1'b0);
    start_seq();
    do_load(1'b0, 17);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    vectors++;
    if (Busy !== 1'b0 || CoreReset !== 1'b1 || LaneIdx !== 5'd0 || ShareIdx !== 1'b0 || InReady !== 1'b0)
      begin miscompares++; $display("FAIL mid_load_reset: got Busy=%b CoreReset=%b lane=%0d share=%0d InReady=%b, expected 0 1 0 0 0", Busy, CoreReset, LaneIdx, ShareIdx, InReady); end
    @(posedge Clock); #1;
    full_run(1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    full_run(1'b0, 1'b1, 4, 1'b1);
    repeat (4) @(posedge Clock);
    #1;
    vectors++;
    if (Busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_noise: got Busy=%b, expected 0", Busy); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0; core_en = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_reset_mid_load();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
